// File: rtl/ddpuf_spi.sv
// SPI mode-0 slave register file for the delay-difference PUF: START/COMPLETE
// handshake, 16-bit measurement Duration and read-only access to the 128-bit response.
module ddpuf_spi (
  input  logic         SCLK,
  input  logic         RST_N,
  input  logic         SS_N,
  input  logic         MOSI,
  output logic         MISO,
  output logic         CLK_OUT,
  input  logic         FSM_Complete,
  output logic         FSM_Start,
  output logic [15:0]  Duration,
  input  logic [127:0] PUF_Val
);

  localparam logic [6:0] ADDR_CTRL  = 7'h00;
  localparam logic [6:0] ADDR_DUR_L = 7'h01;
  localparam logic [6:0] ADDR_DUR_H = 7'h02;

  logic [4:0]  bit_cnt;
  logic [14:0] shift_in;
  logic        start_q;
  logic [7:0]  dur_l;
  logic [7:0]  dur_h;
  logic [7:0]  out_sr;

  logic        commit_write;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;

  assign CLK_OUT = SCLK;

  // The 16th edge completes the frame: command sits in shift_in[14:7], data is shift_in[6:0] plus MOSI.
  assign commit_write = !SS_N && (bit_cnt == 5'd15) && !shift_in[14];
  assign wr_addr      = shift_in[13:7];
  assign wr_data      = {shift_in[6:0], MOSI};

  // After the 8th edge the command byte occupies shift_in[7:0].
  assign rd_req  = shift_in[7];
  assign rd_addr = shift_in[6:0];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves rd_data unassigned (no latch).
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_CTRL:  rd_data = {6'b0, FSM_Complete, start_q};
      ADDR_DUR_L: rd_data = dur_l;
      ADDR_DUR_H: rd_data = dur_h;
      default: begin
        if (rd_addr[6:4] == 3'b001) rd_data = PUF_Val[{rd_addr[3:0], 3'b000} +: 8];
      end
    endcase
  end

  // Rising edge: frame framing, write commit and START auto-clear.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt  <= '0;
      shift_in <= '0;
      start_q  <= 1'b0;
      dur_l    <= '0;
      dur_h    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
      if (SS_N) begin
        bit_cnt  <= '0;
        shift_in <= '0;
      end else if (bit_cnt < 5'd16) begin
        bit_cnt  <= bit_cnt + 5'd1;
        shift_in <= {shift_in[13:0], MOSI};
      end

      if (commit_write && wr_addr == ADDR_CTRL) start_q <= wr_data[0];
      else if (FSM_Complete)                    start_q <= 1'b0;

      if (commit_write && wr_addr == ADDR_DUR_L) dur_l <= wr_data;
      if (commit_write && wr_addr == ADDR_DUR_H) dur_h <= wr_data;
    end
  end

  // Falling edge: load the read snapshot once the command is in, then shift it out MSB first.
  always_ff @(negedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      out_sr <= '0;
    end else if (SS_N || bit_cnt < 5'd8) begin
      out_sr <= '0;
    end else if (bit_cnt == 5'd8) begin
      out_sr <= rd_req ? rd_data : 8'h00;
    end else begin
      out_sr <= {out_sr[6:0], 1'b0};
    end
  end

  assign MISO      = out_sr[7] & !SS_N;
  assign FSM_Start = start_q;
  assign Duration  = {dur_h, dur_l};

endmodule

// File: tb/tb_ddpuf_spi.sv
// Directed bench for ddpuf_spi: drives mode-0 SPI frames from a free-running SCLK
// and compares registers and read-back bytes against hand-computed values.
module tb_ddpuf_spi;

  logic         SCLK = 1'b0;
  logic         RST_N;
  logic         SS_N;
  logic         MOSI;
  logic         MISO;
  logic         CLK_OUT;
  logic         FSM_Complete;
  logic         FSM_Start;
  logic [15:0]  Duration;
  logic [127:0] PUF_Val;

  int n_cmp  = 0;
  int n_fail = 0;

  ddpuf_spi dut (
    .SCLK         (SCLK),
    .RST_N        (RST_N),
    .SS_N         (SS_N),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .CLK_OUT      (CLK_OUT),
    .FSM_Complete (FSM_Complete),
    .FSM_Start    (FSM_Start),
    .Duration     (Duration),
    .PUF_Val      (PUF_Val)
  );

  always #10 SCLK = ~SCLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SS_N-low window of nbits rising edges; bits past 16 drive MOSI high.
  // miso_any ORs MISO over the command byte (read) or the whole frame (write).
  task automatic xfer(input logic [7:0] cmd, input logic [7:0] wdata, input int nbits,
                      output logic [7:0] rd, output logic miso_any);
    logic [15:0] word;
    word     = {cmd, wdata};
    rd       = 8'h00;
    miso_any = 1'b0;
    @(negedge SCLK);
    SS_N = 1'b0;
    MOSI = word[15];
    for (int i = 0; i < nbits; i++) begin
      @(posedge SCLK);
      #1;
      if (i >= 8 && i < 16) rd[15 - i] = MISO;
      if (i < 8 || !cmd[7]) miso_any = miso_any | MISO;
      @(negedge SCLK);
      if (i < 15) MOSI = word[14 - i];
      else        MOSI = 1'b1;
    end
    SS_N = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(posedge SCLK);
    @(negedge SCLK);
  endtask

  logic [7:0]  rd;
  logic        miso_any;
  logic [15:0] word;
  logic        bit_seen;

  initial begin
    RST_N        = 1'b0;
    SS_N         = 1'b1;
    MOSI         = 1'b0;
    FSM_Complete = 1'b0;
    PUF_Val      = 128'hAABBCCDDEEFF00112233445566778899;
    bit_seen     = 1'b0;

    #100;
    check("rst_start", {15'b0, FSM_Start}, 16'h0000);
    check("rst_dur",   Duration,           16'h0000);
    check("rst_miso",  {15'b0, MISO},      16'h0000);
    check("clk_out",   {15'b0, CLK_OUT},   {15'b0, SCLK});
    @(negedge SCLK);
    RST_N = 1'b1;
    repeat (4) @(posedge SCLK);
    @(negedge SCLK);
    check("idle_start", {15'b0, FSM_Start}, 16'h0000);
    check("idle_dur",   Duration,           16'h0000);

    // Duration registers
    xfer(8'h01, 8'hAB, 16, rd, miso_any);
    check("wr_miso_quiet", {15'b0, miso_any}, 16'h0000);
    xfer(8'h02, 8'hCD, 16, rd, miso_any);
    check("dur_cdab", Duration, 16'hCDAB);
    xfer(8'h81, 8'h00, 16, rd, miso_any);
    check("rd_dur_l", {8'h00, rd}, 16'h00AB);
    check("rd_cmd_miso_quiet", {15'b0, miso_any}, 16'h0000);
    xfer(8'h82, 8'h00, 16, rd, miso_any);
    check("rd_dur_h", {8'h00, rd}, 16'h00CD);

    // START handshake and auto-clear
    xfer(8'h00, 8'h01, 16, rd, miso_any);
    check("start_set", {15'b0, FSM_Start}, 16'h0001);
    xfer(8'h80, 8'h00, 16, rd, miso_any);
    check("rd_ctrl_start", {8'h00, rd}, 16'h0001);
    FSM_Complete = 1'b1;
    @(posedge SCLK);
    #1;
    check("start_autoclr", {15'b0, FSM_Start}, 16'h0000);
    xfer(8'h80, 8'h00, 16, rd, miso_any);
    check("rd_ctrl_cmpl", {8'h00, rd}, 16'h0002);
    FSM_Complete = 1'b0;

    // PUF response bytes, read-only
    xfer(8'h90, 8'h00, 16, rd, miso_any);
    check("rd_puf_10", {8'h00, rd}, 16'h0099);
    xfer(8'h95, 8'h00, 16, rd, miso_any);
    check("rd_puf_15", {8'h00, rd}, 16'h0044);
    xfer(8'h9F, 8'h00, 16, rd, miso_any);
    check("rd_puf_1f", {8'h00, rd}, 16'h00AA);
    xfer(8'h10, 8'h00, 16, rd, miso_any);
    xfer(8'h90, 8'h00, 16, rd, miso_any);
    check("puf_ro", {8'h00, rd}, 16'h0099);

    // Aborted write after 12 bits, then a clean frame
    xfer(8'h01, 8'h55, 12, rd, miso_any);
    check("abort_dur", Duration, 16'hCDAB);
    xfer(8'h81, 8'h00, 16, rd, miso_any);
    check("abort_rd", {8'h00, rd}, 16'h00AB);

    // Clocks beyond 16 with SS_N low are ignored
    xfer(8'h02, 8'h5A, 20, rd, miso_any);
    check("extra_clk_dur", Duration, 16'h5AAB);

    // Unmapped address
    xfer(8'h05, 8'hFF, 16, rd, miso_any);
    xfer(8'h85, 8'h00, 16, rd, miso_any);
    check("rd_unmapped", {8'h00, rd}, 16'h0000);
    check("unmapped_dur", Duration, 16'h5AAB);

    // Reset asserted in the middle of a read of 0x1F
    xfer(8'h00, 8'h01, 16, rd, miso_any);
    check("start_set2", {15'b0, FSM_Start}, 16'h0001);
    word = 16'h9F00;
    @(negedge SCLK);
    SS_N = 1'b0;
    MOSI = word[15];
    for (int i = 0; i < 10; i++) begin
      @(posedge SCLK);
      #1;
      if (i == 8) bit_seen = MISO;
      @(negedge SCLK);
      MOSI = word[14 - i];
    end
    check("mid_bit7", {15'b0, bit_seen}, 16'h0001);
    #3 RST_N = 1'b0;
    #1;
    check("midrst_start", {15'b0, FSM_Start}, 16'h0000);
    check("midrst_dur",   Duration,           16'h0000);
    check("midrst_miso",  {15'b0, MISO},      16'h0000);
    SS_N = 1'b1;
    MOSI = 1'b0;
    #40 RST_N = 1'b1;
    repeat (2) @(posedge SCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
